// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty/phase width, the last phase value, and ramp FSM states.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 8;
  localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

  typedef enum logic [0:0] {IDLE, RAMP} ramp_state_t;

endpackage

// File: rtl/pwm_phase_counter.sv
// Free-running PWM phase counter; period_end_o flags the last cycle of each period.
module pwm_phase_counter
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic clk,
  input  logic rst,
  output logic period_end_o
);

  logic [WIDTH-1:0] phase_q, phase_d;

  always_comb phase_d = phase_q + WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign period_end_o = (phase_q == {WIDTH{1'b1}});

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: steps duty_cycle toward a commanded target, changing it
// only on the edge that closes a PWM period so every period runs with a single duty.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH  = PWM_WIDTH,
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  output logic [WIDTH-1:0]  duty_cycle,
  output logic              busy,
  output logic              done,
  output logic              period_end
);

  ramp_state_t       state_q;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic [WIDTH-1:0]  target_q, step_q;
  logic [RATE_W-1:0] rate_q, rate_cnt_q;
  logic              done_q;
  logic [WIDTH-1:0]  diff;

  pwm_phase_counter #(
    .WIDTH(WIDTH)
  ) u_phase (
    .clk         (clk),
    .rst         (rst),
    .period_end_o(period_end)
  );

  // Candidate duty for the next update; clamps to target so it never overshoots or wraps.
  always_comb begin
    diff = (target_q >= duty_q) ? (target_q - duty_q) : (duty_q - target_q);
    if ((step_q == '0) || (step_q >= diff)) begin
      duty_d = target_q;
    end else if (target_q > duty_q) begin
      duty_d = duty_q + step_q;
    end else begin
      duty_d = duty_q - step_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            target_q   <= cmd_target;
            step_q     <= cmd_step;
            rate_q     <= cmd_rate;
            rate_cnt_q <= cmd_rate;
            state_q    <= RAMP;
          end
        end
        RAMP: begin
          // abort takes priority over a coincident period boundary
          if (abort) begin
            state_q <= IDLE;
          end else if (period_end) begin
            if (rate_cnt_q != '0) begin
              rate_cnt_q <= rate_cnt_q - RATE_W'(1);
            end else begin
              duty_q     <= duty_d;
              rate_cnt_q <= rate_q;
              if (duty_d == target_q) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RAMP);
  assign done       = done_q;
  assign duty_cycle = duty_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramp commands, randomized commands
// against an arithmetic ramp model, plus abort and mid-ramp reset sequences.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_target = '0;
  logic [7:0] cmd_step = '0;
  logic [7:0] cmd_rate = '0;
  logic       abort = 1'b0;
  logic [7:0] duty_cycle;
  logic       busy;
  logic       done;
  logic       period_end;

  pwm_ramp_ctrl #(
    .WIDTH (8),
    .RATE_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_step  (cmd_step),
    .cmd_rate  (cmd_rate),
    .abort     (abort),
    .duty_cycle(duty_cycle),
    .busy      (busy),
    .done      (done),
    .period_end(period_end)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;  // rising edges since reset release
  int exp_duty = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int ph();
    return cyc % 256;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ramp: each update moves min(step, distance) toward target; step 0 jumps.
  task automatic build_q(input int t, input int s);
    int d;
    d = exp_duty;
    exp_q.delete();
    do begin
      if (s == 0)     d = t;
      else if (t > d) d = (d + s > t) ? t : d + s;
      else            d = (d - s < t) ? t : d - s;
      exp_q.push_back(8'(d));
    end while (d != t);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 300 && ph() != p; i++) @(negedge clk);
    chk("wait_phase", ph(), p);
  endtask

  // Issue a command at the current negedge and follow it cycle by cycle; update k lands on
  // boundary k*(rate+1) counted after the accept. stop_after>0 returns mid-ramp.
  task automatic run_cmd(input int t, input int s, input int r, input int stop_after);
    int nb, k, n;
    bit upd, fin;
    n = exp_q.size();
    cmd_target = 8'(t);
    cmd_step   = 8'(s);
    cmd_rate   = 8'(r);
    cmd_valid  = 1'b1;
    chk("accept_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    nb = 0;
    k = 0;
    fin = 1'b0;
    for (int c = 0; !fin; c++) begin
      if (c != 0) @(negedge clk);
      upd = 1'b0;
      if (c != 0 && ph() == 0) begin
        nb++;
        if (nb % (r + 1) == 0) begin
          exp_duty = exp_q[k];
          k++;
          upd = 1'b1;
        end
      end
      chk("duty", duty_cycle, exp_duty);
      chk("done", done, int'(upd && k == n));
      chk("busy", busy, int'(!(upd && k == n)));
      chk("period_end", period_end, int'(ph() == 255));
      fin = (upd && k == n) || (stop_after != 0 && k == stop_after);
    end
    if (stop_after == 0) begin
      @(negedge clk);
      chk("done_single", done, 0);
      chk("ready_after", cmd_ready, 1);
      chk("busy_after", busy, 0);
      chk("duty_after", duty_cycle, exp_duty);
    end
  endtask

  typedef struct packed {
    logic [7:0]      t;
    logic [7:0]      s;
    logic [7:0]      r;
    logic [2:0]      n;
    logic [3:0][7:0] seq;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int first_pe, second_pe, npe, s, t, r;

    tbl[0] = '{t: 8'd100, s: 8'd40, r: 8'd0, n: 3'd3, seq: {8'd0, 8'd100, 8'd80, 8'd40}};
    tbl[1] = '{t: 8'd0,   s: 8'd30, r: 8'd1, n: 3'd4, seq: {8'd0, 8'd10, 8'd40, 8'd70}};
    tbl[2] = '{t: 8'd200, s: 8'd0,  r: 8'd5, n: 3'd1, seq: {8'd0, 8'd0, 8'd0, 8'd200}};
    tbl[3] = '{t: 8'd200, s: 8'd7,  r: 8'd0, n: 3'd1, seq: {8'd0, 8'd0, 8'd0, 8'd200}};
    tbl[4] = '{t: 8'd255, s: 8'd50, r: 8'd0, n: 3'd2, seq: {8'd0, 8'd0, 8'd255, 8'd250}};
    tbl[5] = '{t: 8'd0,   s: 8'd0,  r: 8'd2, n: 3'd1, seq: {8'd0, 8'd0, 8'd0, 8'd0}};

    // Reset state and period_end timing
    repeat (3) @(negedge clk);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    chk("idle_ready", cmd_ready, 1);
    first_pe = -1;
    second_pe = -1;
    npe = 0;
    for (int i = 0; i < 512; i++) begin
      if (i != 0) @(negedge clk);
      if (period_end) begin
        npe++;
        if (first_pe < 0) first_pe = i;
        else if (second_pe < 0) second_pe = i;
      end
    end
    chk("pe_first", first_pe, 255);
    chk("pe_second", second_pe, 511);
    chk("pe_count", npe, 2);
    chk("idle_duty", duty_cycle, 0);
    chk("idle_busy", busy, 0);

    // Directed table; even entries are accepted on a boundary cycle, which must not update
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) wait_phase(255);
      exp_q.delete();
      for (int j = 0; j < int'(tbl[i].n); j++) exp_q.push_back(tbl[i].seq[j]);
      run_cmd(int'(tbl[i].t), int'(tbl[i].s), int'(tbl[i].r), 0);
    end

    // Randomized commands; abort toggles while idle and must be ignored
    for (int i = 0; i < 6; i++) begin
      for (int d = $urandom_range(0, 300); d > 0; d--) begin
        abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_duty", duty_cycle, exp_duty);
      end
      abort = 1'b0;
      t = $urandom_range(0, 255);
      s = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(32, 255);
      r = $urandom_range(0, 1);
      build_q(t, s);
      run_cmd(t, s, r, 0);
    end

    // Abort mid-ramp at a boundary with a second command held off
    build_q(0, 0);
    run_cmd(0, 0, 0, 0);
    build_q(250, 10);
    run_cmd(250, 10, 0, 5);
    chk("abort_pre_duty", duty_cycle, 50);
    cmd_valid  = 1'b1;
    cmd_target = 8'd5;
    cmd_step   = 8'd0;
    cmd_rate   = 8'd0;
    for (int i = 0; i < 300 && ph() != 255; i++) begin
      chk("held_ready", cmd_ready, 0);
      chk("held_busy", busy, 1);
      @(negedge clk);
    end
    chk("abort_phase", ph(), 255);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_duty", duty_cycle, 50);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    exp_q.delete();
    exp_q.push_back(8'd5);
    run_cmd(5, 0, 0, 0);

    // Asynchronous reset mid-ramp, then a fresh ramp from phase 0
    build_q(100, 40);
    run_cmd(100, 40, 0, 1);
    chk("pre_rst_duty", duty_cycle, 45);
    wait_phase(100);
    rst = 1'b1;
    #1;
    chk("async_rst_duty", duty_cycle, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_duty = 0;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_pe", period_end, 0);
    exp_q.delete();
    exp_q.push_back(8'd40);
    exp_q.push_back(8'd80);
    exp_q.push_back(8'd100);
    run_cmd(100, 40, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer for the 8-bit PWM generator. It drives that generator's duty_cycle input. It accepts ramp commands (target, step, rate) over a valid/ready handshake and moves duty_cycle toward the target in bounded steps. Every duty change lands exactly at a PWM period boundary, so no period is ever truncated or glitched. It keeps an internal phase counter that is reset-aligned with the generator's free-running counter.

Parameters:
WIDTH, 8, duty/phase width; period = 2^WIDTH clk cycles
RATE_W, 8, width of the periods-per-step divider

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready; high only in IDLE
cmd_target  in  WIDTH  final duty value
cmd_step  in  WIDTH  max duty change per update; 0 = jump directly to target
cmd_rate  in  RATE_W  extra periods between updates; 0 = update every period
abort  in  1  stop an active ramp; duty holds its current value
duty_cycle  out  WIDTH  registered; connects to the PWM generator
busy  out  1  high in RAMP
done  out  1  one-cycle registered pulse when the target is reached
period_end  out  1  high while phase == 2^WIDTH-1 (last cycle of a period)

Behaviour:
- Reset (async): phase=0, state=IDLE, duty_cycle=0, rate_cnt=0, done=0, busy=0. cmd_ready=1 once rst deasserts.
- phase: free-running WIDTH-bit up counter that wraps 2^WIDTH-1 -> 0. It matches the generator's counter cycle-for-cycle because both come out of the same reset.
- boundary = period_end. A duty update is registered on the clk edge where phase==MAX, so the new value is valid when phase==0.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch target, step, rate; load rate_cnt=cmd_rate; go to RAMP.
  - A boundary in the same cycle as the accept applies no update.
  - abort is ignored.
- FSM RAMP:
  - cmd_ready=0 and busy=1. cmd_valid is held off, not queued.
  - At each boundary, if rate_cnt!=0: decrement rate_cnt, duty unchanged.
  - At a boundary with rate_cnt==0:
    - diff = |target - duty|.
    - If step==0 or step>=diff: duty <= target.
    - Else duty <= duty ± step, toward the target.
    - Reload rate_cnt = rate.
  - If that update makes duty == target: done <= 1 for the next cycle, and the state returns to IDLE on the same edge.
  - target == duty at accept: the first qualifying boundary makes no change, pulses done, and returns to IDLE.
- Arithmetic is unsigned WIDTH-bit. A step never overshoots the target, so no wrap-around is possible (0 and 255 are reachable exactly).
- abort in RAMP: return to IDLE next edge; duty holds; no done pulse. If abort and a boundary coincide, abort wins and no update occurs.
- Reset mid-ramp: immediate duty_cycle=0, IDLE, and the latched command is discarded.
- done and busy are never high in the same cycle. done is asserted in the first IDLE cycle.

Decomposition:
- Shared package pwm_pkg: PWM_WIDTH=8, PWM_MAX constant, ramp_state_t enum {IDLE, RAMP}.
- Sub-module pwm_phase_counter (WIDTH): free-running counter plus period_end output. The PWM generator can later reuse it.

Test Plan:
1. Release reset, no cmds -> duty_cycle=0, cmd_ready=1, busy=0; period_end first high at cycle 255 after release, then every 256 cycles.
2. From duty 0, cmd target=100 step=40 rate=0 -> duty 40, 80, 100 at phase 0 of the 1st/2nd/3rd following periods; done pulses once, in the same cycle duty first reads 100; cmd_ready returns to 1.
3. From duty 100, cmd target=0 step=30 rate=1 -> duty 70, 40, 10, 0, one change every 2 periods; no underflow; done at the end.
4. cmd target=200 step=0 rate=5 -> duty holds for 5 boundaries, then jumps 0->200 at the 6th; exactly one update.
5. During a ramp (target=250 step=10), drive cmd_valid with target=5 and assert abort after duty=50 -> the second cmd is not accepted while busy; after abort duty stays 50, no done, cmd_ready=1; the pending cmd is then accepted.
6. Assert rst mid-ramp at phase 100 -> duty_cycle=0 and busy=0 asynchronously; after release phase restarts at 0 and the next cmd behaves as in scenario 2.
